// File: rtl/riscv_timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register word
// indices, CTRL bit positions, the CTRL struct and a byte-masked write helper.
package riscv_timer_pkg;

    localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
    localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
    localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] TMR_CTRL        = 3'd4;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_RELOAD    = 1;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MSB = 15;

    typedef struct packed {
        logic [7:0] presc;
        logic       reload;
        logic       en;
    } ctrl_t;

    // Each mask bit selects whether a byte comes from the new data or keeps its old value.
    function automatic logic [31:0] mask_write(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old;
        for (int k = 0; k < 4; k++)
            if (mask[k]) res[8*k +: 8] = wdata[8*k +: 8];
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick generator for the machine timer: counts 0..presc while enabled and
// produces a one-cycle tick on the terminal count.
module timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] presc,
    output logic       tick
);
    logic [7:0] cnt;

    assign tick = en & (cnt == presc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 8'd0;
        else if (clr)
            cnt <= 8'd0;
        else if (en)
            cnt <= (cnt == presc) ? 8'd0 : cnt + 8'd1;
    end
endmodule

// File: rtl/riscv_timer_intr.sv
// Memory-mapped 64-bit mtime/mtimecmp timer raising the core's timer interrupt.
// Optional prescaler in CTRL[15:8] is built only when TIMER_PRESCALER_EN is defined.
module riscv_timer_intr
    import riscv_timer_pkg::*;
#(
    parameter int DW    = 32,
    parameter int ADDRW = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [3:0]       mask_i,
    output logic [DW-1:0]    rdata_o,
    output logic             t_intr_o
);
    ctrl_t       ctrl;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [2:0]  widx;
    logic        wr;
    logic        ctrl_wr;
    logic        tick;
    logic        hit;
    logic [31:0] ctrl_word;
    logic [31:0] ctrl_new;
    logic        unused_bits;

    assign widx      = addr_i[4:2];
    assign wr        = sel_i & we_i;
    assign ctrl_wr   = wr & (widx == TMR_CTRL);
    assign ctrl_word = {16'h0, ctrl.presc, 6'h0, ctrl.reload, ctrl.en};
    assign ctrl_new  = mask_write(ctrl_word, wdata_i, mask_i);
    assign hit       = ctrl.en & (mtime >= mtimecmp);

    assign unused_bits = ^{addr_i[ADDRW-1:5], addr_i[1:0], ctrl_new[31:16], ctrl_new[7:2]};

`ifdef TIMER_PRESCALER_EN
    timer_prescaler u_presc (
        .clk   (clk_i),
        .rst   (rst_i),
        .en    (ctrl.en),
        .clr   (ctrl_wr),
        .presc (ctrl.presc),
        .tick  (tick)
    );
`else
    assign tick = ctrl.en;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime    <= 64'h0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl     <= '0;
            t_intr_o <= 1'b0;
        end else begin
            // Bus writes to either mtime half beat reload and increment; the other half holds.
            if (wr && widx == TMR_MTIME_LO)
                mtime[31:0] <= mask_write(mtime[31:0], wdata_i, mask_i);
            else if (wr && widx == TMR_MTIME_HI)
                mtime[63:32] <= mask_write(mtime[63:32], wdata_i, mask_i);
            else if (ctrl.reload && hit)
                mtime <= 64'h0;
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wr && widx == TMR_MTIMECMP_LO)
                mtimecmp[31:0] <= mask_write(mtimecmp[31:0], wdata_i, mask_i);
            if (wr && widx == TMR_MTIMECMP_HI)
                mtimecmp[63:32] <= mask_write(mtimecmp[63:32], wdata_i, mask_i);

            if (ctrl_wr) begin
                ctrl.en     <= ctrl_new[CTRL_EN];
                ctrl.reload <= ctrl_new[CTRL_RELOAD];
`ifdef TIMER_PRESCALER_EN
                ctrl.presc  <= ctrl_new[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
`else
                ctrl.presc  <= 8'h0;
`endif
            end

            // Reload zeroes mtime after a hit, so the same registered level is a single pulse there.
            t_intr_o <= hit;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (sel_i) begin
            case (widx)
                TMR_MTIME_LO:    rdata_o = mtime[31:0];
                TMR_MTIME_HI:    rdata_o = mtime[63:32];
                TMR_MTIMECMP_LO: rdata_o = mtimecmp[31:0];
                TMR_MTIMECMP_HI: rdata_o = mtimecmp[63:32];
                TMR_CTRL:        rdata_o = ctrl_word;
                default:         rdata_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_timer_intr.sv
// Directed scoreboard bench for riscv_timer_intr; prescaler checks are
// included when TIMER_PRESCALER_EN is defined.
`timescale 1ns/100ps
module tb_riscv_timer_intr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  mask = 4'hF;
    logic [31:0] rdata;
    logic        t_intr;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          is_intr;
    } sb_t;

    sb_t sb[$];
    int  vectors = 0;
    int  errs = 0;

    riscv_timer_intr #(.DW(32), .ADDRW(12)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .sel_i    (sel),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .mask_i   (mask),
        .rdata_o  (rdata),
        .t_intr_o (t_intr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, vectors %0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic push(input logic [31:0] exp, input bit is_intr, input string tag);
        sb.push_back('{tag, exp, is_intr});
    endtask

    task automatic check_one();
        sb_t e;
        logic [31:0] o;
        e = sb.pop_front();
        o = e.is_intr ? {31'h0, t_intr} : rdata;
        vectors++;
        assert (o === e.exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
        end
    endtask

    task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] m = 4'hF);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = 12'(idx * 4); wdata = d; mask = m;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; mask = 4'hF;
    endtask

    task automatic rd(input int idx, input logic [31:0] exp, input string tag);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = 12'(idx * 4);
        push(exp, 1'b0, tag);
        #1;
        check_one();
        sel = 1'b0;
    endtask

    task automatic obs(input logic [31:0] m, input bit ip, input string tag);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = 12'h0;
        push(m, 1'b0, {tag, "_mtime"});
        push({31'h0, ip}, 1'b1, {tag, "_intr"});
        #1;
        check_one();
        check_one();
        sel = 1'b0;
    endtask

    task automatic chk_intr(input bit ip, input string tag);
        @(negedge clk);
        push({31'h0, ip}, 1'b1, tag);
        #1;
        check_one();
    endtask

    initial begin
        logic [31:0] m;
        bit          ip;
        bit          h;

        #12 rst = 1'b0;

        // Reset state
        rd(0, 32'h0, "rst_mtime_lo");
        rd(1, 32'h0, "rst_mtime_hi");
        rd(2, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(3, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(4, 32'h0, "rst_ctrl");
        rd(5, 32'h0, "rst_unmapped");
        chk_intr(1'b0, "rst_intr");

        // Unmapped write ignored, CTRL reserved bits
        wr(5, 32'hDEAD_BEEF);
        rd(5, 32'h0, "unmapped_wr");
        wr(4, 32'h0000_0302);
`ifdef TIMER_PRESCALER_EN
        rd(4, 32'h0000_0302, "ctrl_presc");
`else
        rd(4, 32'h0000_0002, "ctrl_presc");
`endif
        wr(4, 32'hFFFF_FFFC);
`ifdef TIMER_PRESCALER_EN
        rd(4, 32'h0000_FC00, "ctrl_rsvd");
`else
        rd(4, 32'h0, "ctrl_rsvd");
`endif

        // One-shot compare at 10
        wr(2, 32'd10);
        wr(3, 32'd0);
        wr(4, 32'h1);
        m = 0; ip = 1'b0;
        for (int k = 0; k < 15; k++) begin
            obs(m, ip, "oneshot");
            ip = (m >= 10);
            m = m + 1;
        end
        wr(2, 32'd100);
        obs(m + 1, 1'b1, "cmp_raise_a");
        obs(m + 2, 1'b0, "cmp_raise_b");

        // Reload mode, period 5
        wr(4, 32'h0);
        wr(0, 32'h0);
        wr(2, 32'd4);
        wr(4, 32'h3);
        m = 0; ip = 1'b0;
        for (int k = 0; k < 15; k++) begin
            obs(m, ip, "reload");
            h = (m >= 4);
            ip = h;
            m = h ? 32'h0 : m + 1;
        end

        // Carry LO->HI and byte-masked write
        wr(4, 32'h0);
        wr(3, 32'hFFFF_FFFF);
        wr(0, 32'hFFFF_FFFE);
        wr(1, 32'h0);
        wr(4, 32'h1);
        rd(0, 32'hFFFF_FFFE, "carry_lo0");
        rd(0, 32'hFFFF_FFFF, "carry_lo1");
        rd(1, 32'h1, "carry_hi");
        wr(4, 32'h0);
        rd(0, 32'h2, "frozen_lo");
        rd(4, 32'h0, "ctrl_off");
        wr(0, 32'h0000_AB00, 4'b0010);
        rd(0, 32'h0000_AB02, "bytewr_lo");
        rd(1, 32'h1, "bytewr_hi");
        @(negedge clk);
        sel = 1'b0; addr = 12'h0;
        push(32'h0, 1'b0, "nosel");
        #1;
        check_one();

`ifdef TIMER_PRESCALER_EN
        // Prescaler 3: one tick per 4 cycles, CTRL write restarts phase
        wr(0, 32'h0);
        wr(1, 32'h0);
        wr(4, 32'h0000_0301);
        for (int k = 1; k <= 10; k++)
            rd(0, 32'((k - 1) / 4), "presc");
        wr(4, 32'h0000_0301);
        for (int j = 1; j <= 6; j++)
            rd(0, 32'(2 + (j - 1) / 4), "presc_restart");
        wr(4, 32'h0);
`endif

        // Asynchronous reset while interrupt is high
        wr(2, 32'h0);
        wr(3, 32'h0);
        wr(4, 32'h1);
        chk_intr(1'b0, "pre_rst_intr0");
        chk_intr(1'b1, "pre_rst_intr1");
        #0.5 rst = 1'b1;
        #0.5;
        push(32'h0, 1'b1, "arst_intr");
        check_one();
        sel = 1'b1; addr = 12'h0;
        #0.5;
        push(32'h0, 1'b0, "arst_mtime_lo");
        check_one();
        addr = 12'h4;
        #0.5;
        push(32'h0, 1'b0, "arst_mtime_hi");
        check_one();
        addr = 12'hC;
        #0.5;
        push(32'hFFFF_FFFF, 1'b0, "arst_cmp_hi");
        check_one();
        addr = 12'h10;
        #0.5;
        push(32'h0, 1'b0, "arst_ctrl");
        check_one();
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(2, 32'hFFFF_FFFF, "post_rst_cmp_lo");
        chk_intr(1'b0, "post_rst_intr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/riscv_timer_intr.md
# riscv_timer_intr

Memory-mapped 64-bit machine timer that generates the core's timer interrupt (`t_intr`), i.e. the initiator side of the interrupt that the core's CSR unit latches into `mip.MTIP`. It sits on the core's data bus beside the data memory. It is selected by an external address decoder and exposes `mtime`, `mtimecmp` and a control register. It raises `t_intr_o` when the running counter reaches the compare value, either once or periodically.

## Interface
Parameters:
- `DW`, 32: bus data width; only 32 is supported.
- `ADDRW`, 12: bus address width; only `addr_i[4:2]` is decoded.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `sel_i`, in, 1: block selected by the external decoder this cycle.
- `we_i`, in, 1: write strobe; qualified by `sel_i`.
- `addr_i`, in, ADDRW: byte address; word index is `addr_i[4:2]`.
- `wdata_i`, in, DW: write data.
- `mask_i`, in, 4: byte enables for writes; bit k covers `wdata_i[8k+7:8k]`.
- `rdata_o`, out, DW: read data. Combinational from the registers. Equals 0 when `sel_i`=0 or when the address is unmapped.
- `t_intr_o`, out, 1: timer interrupt request to the core. Registered.

## Operation
- Register map (word index):
  - 0: `MTIME_LO`.
  - 1: `MTIME_HI`.
  - 2: `MTIMECMP_LO`.
  - 3: `MTIMECMP_HI`.
  - 4: `CTRL`, with fields `[0]` EN, `[1]` RELOAD, `[15:8]` PRESC (PRESC only with the macro); other bits read 0.
  - Indices 5–7 are unmapped: reads return 0 and writes are ignored.
- Reset values:
  - `mtime` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt fires before configuration.
  - `CTRL` = 0.
  - prescale counter = 0.
  - `t_intr_o` = 0.
  - `rdata_o` follows the register values.
- Counting:
  - When EN=1, `mtime` increments by 1 on every tick, carrying from LO into HI.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0 with no flag.
  - EN=0 freezes `mtime`.
- A bus write to `MTIME_LO`/`MTIME_HI` in the same cycle as a tick: the write wins and the increment is dropped that cycle. Writing one half never carries into or modifies the other half.
- Comparison is unsigned 64-bit: `hit` = EN & (`mtime` >= `mtimecmp`), evaluated on the current register values.
- One-shot mode (RELOAD=0):
  - `t_intr_o` is a level equal to `hit` delayed one cycle.
  - It stays high until software raises `mtimecmp`, lowers `mtime`, or clears EN.
- Reload mode (RELOAD=1):
  - When `hit`, the next `mtime` = 0, regardless of the tick and overriding any increment.
  - `t_intr_o` pulses high for exactly one cycle per hit.
  - A simultaneous bus write to `MTIME_*` overrides the reload.
  - With `mtimecmp` = 0, `hit` is true every cycle and `t_intr_o` stays high.
- Writing `CTRL` clears the prescale counter. Clearing EN drops `t_intr_o` on the next cycle.
- Reset asserted mid-count immediately forces all state to its reset values. No partial write survives.

## Timing
- Read latency 0: `rdata_o` is valid in the same cycle as `sel_i` and returns pre-write values during a write cycle.
- Write latency 1: the register holds the new value after the next `clk_i` rising edge.
- The comparison result reaches `t_intr_o` after 1 cycle. A write to `mtimecmp` that creates a hit at edge n shows `t_intr_o`=1 after edge n+1.
- There is no handshake or wait state. Every selected access completes in one cycle.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - CTRL[15:8] PRESC is implemented.
  - An 8-bit prescale counter counts 0..PRESC and generates a tick when it equals PRESC, then wraps to 0.
  - PRESC=0 gives a tick every cycle.
- `TIMER_PRESCALER_EN` undefined: CTRL[15:8] reads 0 and ignores writes, and the tick equals EN every cycle.

## Structure
- Package `riscv_timer_pkg`:
  - word-index constants `TMR_MTIME_LO`..`TMR_CTRL`.
  - CTRL bit positions `CTRL_EN`, `CTRL_RELOAD`, `CTRL_PRESC_LSB/MSB`.
  - a packed `ctrl_t` struct.
- Sub-module `timer_prescaler`: the tick generator, instantiated only under `TIMER_PRESCALER_EN`.
- Counter, compare, bus decode and byte-masked writes stay in the top block.

## Test plan
- Reset, then read all five words: `mtime`=0, `mtimecmp`=all ones, CTRL=0, `t_intr_o`=0. Reading index 5 returns 0.
- Write `MTIMECMP_LO`=10, `MTIMECMP_HI`=0, CTRL=1. `t_intr_o` rises exactly 1 cycle after `mtime` reads 10 and stays high. Writing `MTIMECMP_LO`=100 drops it 1 cycle later.
- RELOAD: CTRL=3, `mtimecmp`=4. `t_intr_o` is a one-cycle pulse every 5 cycles and `mtime` cycles 0..4.
- Write `MTIME_LO`=FFFF_FFFE, `MTIME_HI`=0, enable. After 2 cycles read HI=1, LO=0. Then a byte write with `mask_i`=4'b0010 and `wdata_i`=32'h0000_AB00 changes only `mtime[15:8]` to 8'hAB.
- `TIMER_PRESCALER_EN`, PRESC=3: `mtime` increments once per 4 cycles. Rewriting CTRL restarts the 4-cycle phase.
- Assert `rst_i` asynchronously between edges while `t_intr_o`=1: `t_intr_o` and all registers return to reset values before the next edge.
